// File: rtl/program_loader_if.sv
// Byte stream from the host link plus the instruction-memory write port,
// bundled so the loader and its neighbours share one connection.
interface program_loader_if #(
    parameter int INST_MEM_WIDTH = 2
);
    logic [7:0]                rx_data;
    logic                      rx_valid;
    logic [INST_MEM_WIDTH-1:0] mem_addr;
    logic [31:0]               mem_data;
    logic                      mem_we;

    modport master (
        output rx_data, rx_valid,
        input  mem_addr, mem_data, mem_we
    );

    modport slave (
        input  rx_data, rx_valid,
        output mem_addr, mem_data, mem_we
    );
endinterface

// File: rtl/program_loader.sv
// Parses a length-prefixed big-endian program image from the host byte stream
// and writes it into instruction memory from address 0, stalling fetch meanwhile.
module program_loader #(
    parameter int INST_MEM_WIDTH = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    program_loader_if.slave  bus,
    output logic             loading,
    output logic             done,
    output logic             error
);

    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [32:0] DEPTH    = 33'(2 ** INST_MEM_WIDTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LEN, DATA, FIN} state_t;

    state_t                    state, state_n;
    logic [1:0]                byte_cnt, byte_cnt_n;
    logic [INST_MEM_WIDTH-1:0] word_cnt, word_cnt_n;
    logic [31:0]               len_reg, len_n;
    logic [31:0]               shift_reg, shift_n;
    logic [TW-1:0]             tmo_cnt, tmo_n;
    logic [INST_MEM_WIDTH-1:0] addr_q, addr_n;
    logic [31:0]               data_q, data_n;
    logic                      we_q, we_n;
    logic                      loading_n, done_n, error_n;
    logic [31:0]               assembled;

    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.mem_we   = we_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            word_cnt  <= '0;
            len_reg   <= '0;
            shift_reg <= '0;
            tmo_cnt   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            loading   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            byte_cnt  <= byte_cnt_n;
            word_cnt  <= word_cnt_n;
            len_reg   <= len_n;
            shift_reg <= shift_n;
            tmo_cnt   <= tmo_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            we_q      <= we_n;
            loading   <= loading_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        word_cnt_n = word_cnt;
        len_n      = len_reg;
        shift_n    = shift_reg;
        tmo_n      = tmo_cnt;
        addr_n     = addr_q;
        data_n     = data_q;
        we_n       = 1'b0;
        done_n     = 1'b0;
        error_n    = error;
        assembled  = {shift_reg[23:0], bus.rx_data};

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = LEN;
                    error_n    = 1'b0;
                    byte_cnt_n = '0;
                    word_cnt_n = '0;
                    len_n      = '0;
                    shift_n    = '0;
                    tmo_n      = '0;
                end
            end
            LEN, DATA: begin
                if (bus.rx_valid) begin
                    tmo_n      = '0;
                    shift_n    = assembled;
                    byte_cnt_n = byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        if (state == LEN) begin
                            len_n = assembled;
                            // Oversize images are rejected before any write
                            if (assembled == 32'd0) begin
                                state_n = FIN;
                            end else if ({1'b0, assembled} > DEPTH) begin
                                error_n = 1'b1;
                                state_n = IDLE;
                            end else begin
                                state_n = DATA;
                            end
                        end else begin
                            we_n       = 1'b1;
                            data_n     = assembled;
                            addr_n     = word_cnt;
                            word_cnt_n = word_cnt + 1'b1;
                            if (32'(word_cnt) == len_reg - 32'd1) begin
                                state_n = FIN;
                            end
                        end
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    error_n    = 1'b1;
                    state_n    = IDLE;
                    tmo_n      = '0;
                    byte_cnt_n = '0;
                end else begin
                    tmo_n = tmo_cnt + TW'(1);
                end
            end
            FIN: begin
                // First FIN cycle raises done; the second returns to IDLE
                if (done) begin
                    state_n = IDLE;
                end else begin
                    done_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        loading_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: contiguous and spaced loads, empty and
// oversize images, byte timeout and asynchronous reset mid-load.
module tb_program_loader;

    logic CLK = 1'b0;
    logic reset;
    logic start;
    logic loading, done, error;

    int check_count = 0;
    int pass_count  = 0;

    int          wr_cnt   = 0;
    int          done_cnt = 0;
    logic [1:0]  wr_addr [8];
    logic [31:0] wr_data [8];

    program_loader_if #(.INST_MEM_WIDTH(2)) bus ();

    program_loader #(
        .INST_MEM_WIDTH(2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK    (CLK),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .loading(loading),
        .done   (done),
        .error  (error)
    );

    always #5 CLK = ~CLK;

    // Logs every memory write and done pulse seen between clock edges
    always @(negedge CLK) begin
        if (bus.mem_we) begin
            if (wr_cnt < 8) begin
                wr_addr[wr_cnt] = bus.mem_addr;
                wr_data[wr_cnt] = bus.mem_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge CLK);
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        tick(gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic clear_log();
        wr_cnt   = 0;
        done_cnt = 0;
    endtask

    logic [7:0] img2 [12] = '{8'h00, 8'h00, 8'h00, 8'h02,
                              8'h12, 8'h34, 8'h56, 8'h78,
                              8'h9A, 8'hBC, 8'hDE, 8'hF0};

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        #1;
        checkOutput("reset_we",      32'(bus.mem_we),   32'd0);
        checkOutput("reset_addr",    32'(bus.mem_addr), 32'd0);
        checkOutput("reset_data",    bus.mem_data,      32'd0);
        checkOutput("reset_loading", 32'(loading),      32'd0);
        checkOutput("reset_done",    32'(done),         32'd0);
        checkOutput("reset_error",   32'(error),        32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);

        $display("[TB] contiguous two-word load");
        clear_log();
        pulse_start();
        checkOutput("t1_loading_after_start", 32'(loading), 32'd1);
        for (int i = 0; i < 8; i++) applyStimulus(img2[i], 0);
        checkOutput("t1_we0",   32'(bus.mem_we),   32'd1);
        checkOutput("t1_addr0", 32'(bus.mem_addr), 32'd0);
        checkOutput("t1_data0", bus.mem_data,      32'h12345678);
        for (int i = 8; i < 12; i++) applyStimulus(img2[i], 0);
        checkOutput("t1_we1",     32'(bus.mem_we),   32'd1);
        checkOutput("t1_addr1",   32'(bus.mem_addr), 32'd1);
        checkOutput("t1_data1",   bus.mem_data,      32'h9ABCDEF0);
        checkOutput("t1_done_early", 32'(done),      32'd0);
        tick(1);
        checkOutput("t1_done",         32'(done),        32'd1);
        checkOutput("t1_loading_done", 32'(loading),     32'd1);
        checkOutput("t1_we_off",       32'(bus.mem_we),  32'd0);
        tick(1);
        checkOutput("t1_done_once",    32'(done),    32'd0);
        checkOutput("t1_loading_off",  32'(loading), 32'd0);
        checkOutput("t1_error",        32'(error),   32'd0);
        tick(1);
        checkOutput("t1_wr_cnt",   32'(wr_cnt),   32'd2);
        checkOutput("t1_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] empty image");
        clear_log();
        pulse_start();
        for (int i = 0; i < 4; i++) applyStimulus(8'h00, 0);
        checkOutput("t2_loading_fin", 32'(loading), 32'd1);
        checkOutput("t2_done_early",  32'(done),    32'd0);
        tick(1);
        checkOutput("t2_done", 32'(done), 32'd1);
        tick(1);
        checkOutput("t2_loading_off", 32'(loading), 32'd0);
        checkOutput("t2_error",       32'(error),   32'd0);
        tick(1);
        checkOutput("t2_wr_cnt",   32'(wr_cnt),   32'd0);
        checkOutput("t2_done_cnt", 32'(done_cnt), 32'd1);

        $display("[TB] oversize image");
        clear_log();
        pulse_start();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h05, 0);
        checkOutput("t3_error",   32'(error),   32'd1);
        checkOutput("t3_loading", 32'(loading), 32'd0);
        tick(4);
        checkOutput("t3_error_sticky", 32'(error),    32'd1);
        checkOutput("t3_wr_cnt",       32'(wr_cnt),   32'd0);
        checkOutput("t3_done_cnt",     32'(done_cnt), 32'd0);
        pulse_start();
        checkOutput("t3_error_cleared", 32'(error),   32'd0);
        checkOutput("t3_loading_again", 32'(loading), 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(8'h00, 0);
        tick(3);

        $display("[TB] byte timeout");
        clear_log();
        pulse_start();
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'hAA, 0);
        applyStimulus(8'hBB, 0);
        tick(7);
        checkOutput("t4_error_before", 32'(error),   32'd0);
        checkOutput("t4_loading_wait", 32'(loading), 32'd1);
        tick(1);
        checkOutput("t4_error",   32'(error),   32'd1);
        checkOutput("t4_loading", 32'(loading), 32'd0);
        checkOutput("t4_wr_cnt",  32'(wr_cnt),  32'd0);

        $display("[TB] spaced bytes with stray start");
        clear_log();
        pulse_start();
        checkOutput("t5_error_cleared", 32'(error), 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (i == 6) start = 1'b1;
            applyStimulus(img2[i], (i == 11) ? 0 : 3);
            start = 1'b0;
        end
        checkOutput("t5_we1", 32'(bus.mem_we), 32'd1);
        tick(1);
        checkOutput("t5_done", 32'(done), 32'd1);
        tick(2);
        checkOutput("t5_wr_cnt",   32'(wr_cnt),     32'd2);
        checkOutput("t5_addr0",    32'(wr_addr[0]), 32'd0);
        checkOutput("t5_data0",    wr_data[0],      32'h12345678);
        checkOutput("t5_addr1",    32'(wr_addr[1]), 32'd1);
        checkOutput("t5_data1",    wr_data[1],      32'h9ABCDEF0);
        checkOutput("t5_done_cnt", 32'(done_cnt),   32'd1);
        checkOutput("t5_error",    32'(error),      32'd0);
        checkOutput("t5_loading",  32'(loading),    32'd0);

        $display("[TB] asynchronous reset mid-load");
        clear_log();
        pulse_start();
        for (int i = 0; i < 8; i++) applyStimulus(img2[i], 0);
        applyStimulus(8'h9A, 0);
        applyStimulus(8'hBC, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_loading", 32'(loading),      32'd0);
        checkOutput("t6_data",    bus.mem_data,      32'd0);
        checkOutput("t6_addr",    32'(bus.mem_addr), 32'd0);
        checkOutput("t6_we",      32'(bus.mem_we),   32'd0);
        checkOutput("t6_done",    32'(done),         32'd0);
        checkOutput("t6_error",   32'(error),        32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        clear_log();
        pulse_start();
        for (int i = 0; i < 12; i++) applyStimulus(img2[i], 0);
        tick(3);
        checkOutput("t6_wr_cnt", 32'(wr_cnt),     32'd2);
        checkOutput("t6_addr0",  32'(wr_addr[0]), 32'd0);
        checkOutput("t6_data0",  wr_data[0],      32'h12345678);
        checkOutput("t6_addr1",  32'(wr_addr[1]), 32'd1);
        checkOutput("t6_data1",  wr_data[1],      32'h9ABCDEF0);
        checkOutput("t6_done_cnt", 32'(done_cnt), 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream neighbour of the instruction-fetch stage. Takes the serial byte stream from the host link (UART receiver), parses a length-prefixed program image, and writes 32-bit big-endian instruction words into instruction memory at sequential addresses from 0.
- Holds `loading` high while a load is in progress, so fetch can stall on it.
- Pulses `done` on completion.
- Flags `error` on an oversize image or a byte timeout.

Parameters:
- INST_MEM_WIDTH, 2, instruction memory address width; depth = 2**INST_MEM_WIDTH words.
- TIMEOUT_CYCLES, 1000000, max idle cycles between bytes during a load before abort; must be >= 1.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid this cycle; single-cycle per byte, no backpressure.
- mem_addr  output  INST_MEM_WIDTH  write address to instruction memory.
- mem_data  output  32  write data (assembled word).
- mem_we  output  1  one-cycle write strobe.
- loading  output  1  high while state is LEN, DATA or FIN.
- done  output  1  one-cycle pulse on successful completion.
- error  output  1  sticky; set on abort, cleared on next accepted start.

Behaviour:
- Reset (async, active-high; released synchronously to CLK by the reset source). Required values:
  - state=IDLE;
  - mem_addr, mem_data = 0; mem_we, loading, done, error = 0;
  - byte counter, word counter, length register and timeout counter = 0.
- All outputs are registered.
- States:
  - IDLE: ignores rx_valid. On start: clear error and counters, go to LEN.
  - LEN: collects 4 bytes on rx_valid into a 32-bit count N, first byte = bits 31:24. On the 4th byte:
    - if N == 0, go to FIN;
    - if N > 2**INST_MEM_WIDTH, set error and go to IDLE (no writes);
    - otherwise go to DATA.
  - DATA: shifts bytes into a word, first byte = bits 31:24. On the 4th byte of each word:
    - next cycle: mem_we=1, mem_data=word, mem_addr=word index (0,1,2,...);
    - word index increments after the write;
    - when the written word is word N-1, go to FIN in the same cycle mem_we is asserted.
  - FIN: done=1 for exactly one cycle, loading still 1; next cycle go to IDLE with loading=0.
- Latency:
  - mem_we asserts 1 cycle after the rx_valid of a word's 4th byte.
  - done asserts 1 cycle after the final mem_we.
- Back-to-back rx_valid (every cycle) is fully supported; no bytes are lost.
- Timeout: in LEN or DATA, the timeout counter increments each cycle without rx_valid and resets to 0 on rx_valid.
  - On reaching TIMEOUT_CYCLES: set error, go to IDLE, discard the partial word.
  - Words already written remain in memory.
- Simultaneous events:
  - start outside IDLE is ignored.
  - rx_valid on the cycle start is accepted in IDLE is ignored; the first counted byte is the next rx_valid.
  - Bytes arriving in IDLE or FIN are dropped.
- Address never wraps: the N <= depth check guarantees mem_addr <= depth-1.
- Reset mid-load: immediate return to IDLE with all outputs 0; no further writes.

Test Plan:
- Reset, then start, then bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 every cycle -> mem_we at addr 0 data 0x12345678, then addr 1 data 0x9ABCDEF0; done pulse 1 cycle after the 2nd write; loading high from the cycle after start through the done cycle; error=0.
- Start, then 00 00 00 00 -> no mem_we; done pulses; error=0.
- Default depth 4: start, then 00 00 00 05 -> error=1, state IDLE, no mem_we, done never pulses; next start clears error.
- TIMEOUT_CYCLES=8: start, length 1, bytes AA BB, then silence -> error=1 exactly 8 cycles after BB; no mem_we; loading=0.
- Bytes spaced 3 idle cycles apart, plus a start pulse mid-DATA -> writes identical to the contiguous case; mid-load start ignored.
- Assert reset asynchronously between bytes of word 1 -> all outputs 0 immediately (before the next edge); a subsequent full load succeeds from addr 0.
